// File: rtl/boot_load_ctrl.sv
// rtl/boot_load_ctrl.sv - boot loader sequencer: stream header + data words + program words into BRAMs, then release the core
//
// Ports:
//   clk, rst (sync, active-low), start      control
//   s_valid, s_data, s_ready                 incoming word stream
//   d_w_addr, d_w_dat, d_w_enb               data BRAM write port
//   i_w_addr, i_w_dat, i_w_enb               instruction BRAM write port
//   d_bram_init_done                         data BRAM port owned by the datapath
//   pc_stall, i_r_enb, rd_enbl               core run controls
//   busy, done, err                          loader status

module boot_load_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int I_WORDS    = 256,
  parameter int D_WORDS    = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic [ADDR_WIDTH-1:0] d_w_addr,
  output logic [DATA_WIDTH-1:0] d_w_dat,
  output logic                  d_w_enb,
  output logic [ADDR_WIDTH-1:0] i_w_addr,
  output logic [DATA_WIDTH-1:0] i_w_dat,
  output logic                  i_w_enb,
  output logic                  d_bram_init_done,
  output logic                  pc_stall,
  output logic                  i_r_enb,
  output logic                  rd_enbl,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  // One extra bit so a count equal to capacity is representable.
  localparam int CW = ADDR_WIDTH - 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_LOAD_D,
    S_LOAD_I,
    S_FLUSH,
    S_RUN,
    S_ERR
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_dcnt;
  logic [CW-1:0] r_icnt;

  logic          w_hs;
  logic [15:0]   w_hdr_i;
  logic [15:0]   w_hdr_d;
  logic          w_hdr_bad;
  logic [CW-1:0] w_cnt_inc;
  logic          w_d_last;
  logic          w_i_last;
  logic          w_d_wr;
  logic          w_i_wr;

  assign w_hs      = s_valid & s_ready;
  assign w_hdr_i   = s_data[31:16];
  assign w_hdr_d   = s_data[15:0];
  assign w_hdr_bad = (w_hdr_d > 16'(D_WORDS)) || (w_hdr_i > 16'(I_WORDS));
  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_d_last  = (w_cnt_inc == r_dcnt);
  assign w_i_last  = (w_cnt_inc == r_icnt);
  assign w_d_wr    = (r_state == S_LOAD_D) && w_hs;
  assign w_i_wr    = (r_state == S_LOAD_I) && w_hs;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_HDR;
      end
      S_HDR: begin
        if (w_hs) begin
          if (w_hdr_bad)           w_next = S_ERR;
          else if (w_hdr_d != '0)  w_next = S_LOAD_D;
          else if (w_hdr_i != '0)  w_next = S_LOAD_I;
          else                     w_next = S_FLUSH;
        end
      end
      S_LOAD_D: begin
        if (w_hs && w_d_last) w_next = (r_icnt != '0) ? S_LOAD_I : S_FLUSH;
      end
      S_LOAD_I: begin
        if (w_hs && w_i_last) w_next = S_FLUSH;
      end
      S_FLUSH: begin
        w_next = S_RUN;
      end
      S_RUN: begin
        if (start) w_next = S_HDR;
      end
      S_ERR: begin
        if (start) w_next = S_HDR;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Header capture and per-phase word counter; the counter restarts at each phase
  // so both BRAMs are written from byte address 0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt  <= '0;
      r_dcnt <= '0;
      r_icnt <= '0;
    end else begin
      if (r_state == S_HDR) begin
        r_cnt <= '0;
        if (w_hs) begin
          r_dcnt <= w_hdr_d[CW-1:0];
          r_icnt <= w_hdr_i[CW-1:0];
        end
      end else if (w_d_wr) begin
        r_cnt <= w_d_last ? '0 : w_cnt_inc;
      end else if (w_i_wr) begin
        r_cnt <= w_i_last ? '0 : w_cnt_inc;
      end
    end
  end

  // Every output is registered from the next state so it lines up with the state it describes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s_ready          <= 1'b0;
      d_w_addr         <= '0;
      d_w_dat          <= '0;
      d_w_enb          <= 1'b0;
      i_w_addr         <= '0;
      i_w_dat          <= '0;
      i_w_enb          <= 1'b0;
      d_bram_init_done <= 1'b0;
      pc_stall         <= 1'b1;
      i_r_enb          <= 1'b0;
      rd_enbl          <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      err              <= 1'b0;
    end else begin
      s_ready <= (w_next == S_HDR) || (w_next == S_LOAD_D) || (w_next == S_LOAD_I);

      d_w_enb <= w_d_wr;
      if (w_d_wr) begin
        d_w_addr <= {r_cnt[ADDR_WIDTH-3:0], 2'b00};
        d_w_dat  <= s_data;
      end

      i_w_enb <= w_i_wr;
      if (w_i_wr) begin
        i_w_addr <= {r_cnt[ADDR_WIDTH-3:0], 2'b00};
        i_w_dat  <= s_data;
      end

      // Hand the data BRAM to the datapath only once the last loader write has retired,
      // so the mux never switches under a live write pulse.
      d_bram_init_done <= ((w_next == S_LOAD_I) || (w_next == S_FLUSH) || (w_next == S_RUN))
                          && !w_d_wr;

      pc_stall <= (w_next != S_RUN);
      i_r_enb  <= (w_next == S_RUN);
      rd_enbl  <= (w_next == S_RUN);
      busy     <= (w_next == S_HDR) || (w_next == S_LOAD_D) ||
                  (w_next == S_LOAD_I) || (w_next == S_FLUSH);
      done     <= (w_next == S_RUN) && (r_state != S_RUN);
      err      <= (w_next == S_ERR);
    end
  end

endmodule

// File: tb/tb_boot_load_ctrl.sv
// tb/tb_boot_load_ctrl.sv - directed self-checking bench for boot_load_ctrl

module tb_boot_load_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        s_valid = 1'b0;
  logic [31:0] s_data = '0;
  logic        s_ready;
  logic [9:0]  d_w_addr;
  logic [31:0] d_w_dat;
  logic        d_w_enb;
  logic [9:0]  i_w_addr;
  logic [31:0] i_w_dat;
  logic        i_w_enb;
  logic        d_bram_init_done;
  logic        pc_stall;
  logic        i_r_enb;
  logic        rd_enbl;
  logic        busy;
  logic        done;
  logic        err;

  boot_load_ctrl #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(10),
    .I_WORDS(256),
    .D_WORDS(256)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .s_valid(s_valid),
    .s_data(s_data),
    .s_ready(s_ready),
    .d_w_addr(d_w_addr),
    .d_w_dat(d_w_dat),
    .d_w_enb(d_w_enb),
    .i_w_addr(i_w_addr),
    .i_w_dat(i_w_dat),
    .i_w_enb(i_w_enb),
    .d_bram_init_done(d_bram_init_done),
    .pc_stall(pc_stall),
    .i_r_enb(i_r_enb),
    .rd_enbl(rd_enbl),
    .busy(busy),
    .done(done),
    .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] d_addr_q[$];
  logic [31:0] d_dat_q[$];
  logic [31:0] i_addr_q[$];
  logic [31:0] i_dat_q[$];
  int edge_n = 0;
  int last_hs_edge = -1;
  int last_d_edge = -1;
  int init_rise_edge = -1;
  int stall_fall_edge = -1;
  int n_enb = 0;
  int n_done = 0;
  int n_overlap = 0;
  logic prev_init = 1'b0;
  logic prev_stall = 1'b1;

  always @(posedge clk) begin
    if (s_valid && s_ready) last_hs_edge = edge_n;
    edge_n++;
  end

  always @(negedge clk) begin
    int cur;
    cur = edge_n - 1;
    if (d_w_enb) begin
      d_addr_q.push_back(32'(d_w_addr));
      d_dat_q.push_back(d_w_dat);
      last_d_edge = cur;
      n_enb++;
    end
    if (i_w_enb) begin
      i_addr_q.push_back(32'(i_w_addr));
      i_dat_q.push_back(i_w_dat);
      n_enb++;
    end
    if (d_w_enb && d_bram_init_done) n_overlap++;
    if (d_bram_init_done && !prev_init) init_rise_edge = cur;
    if (!pc_stall && prev_stall) stall_fall_edge = cur;
    if (done) n_done++;
    prev_init  = d_bram_init_done;
    prev_stall = pc_stall;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    d_addr_q.delete();
    d_dat_q.delete();
    i_addr_q.delete();
    i_dat_q.delete();
    last_d_edge = -1;
    init_rise_edge = -1;
    stall_fall_edge = -1;
    n_enb = 0;
    n_done = 0;
    n_overlap = 0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Offer one word after `gap` idle cycles; returns once it has been accepted.
  task automatic send(input logic [31:0] w, input int gap);
    logic rdy;
    repeat (gap) begin
      s_valid = 1'b0;
      tick();
    end
    s_valid = 1'b1;
    s_data  = w;
    for (int t = 0; t < 40; t++) begin
      rdy = s_ready;
      tick();
      if (rdy) begin
        s_valid = 1'b0;
        return;
      end
    end
    s_valid = 1'b0;
    check("send_timeout", 32'd0, 32'd1);
  endtask

  function automatic logic [31:0] data_w(input int k);
    return 32'hda7a_0000 + 32'(k);
  endfunction

  function automatic logic [31:0] jalr_w(input int k);
    return {12'(4 * k), 5'd1, 3'b000, 5'd0, 7'b1100111};
  endfunction

  task automatic send_load(input logic [31:0] hdr, input int nd, input int ni, input int gap);
    send(hdr, 0);
    for (int k = 0; k < nd; k++) send(data_w(k), gap);
    for (int k = 0; k < ni; k++) send(jalr_w(k), gap);
  endtask

  task automatic verify_load(input string tag, input int nd, input int ni);
    check({tag, "_d_count"}, 32'(d_addr_q.size()), 32'(nd));
    check({tag, "_i_count"}, 32'(i_addr_q.size()), 32'(ni));
    for (int k = 0; k < nd && k < d_addr_q.size(); k++) begin
      check({tag, "_d_addr"}, d_addr_q[k], 32'(4 * k));
      check({tag, "_d_dat"}, d_dat_q[k], data_w(k));
    end
    for (int k = 0; k < ni && k < i_addr_q.size(); k++) begin
      check({tag, "_i_addr"}, i_addr_q[k], 32'(4 * k));
      check({tag, "_i_dat"}, i_dat_q[k], jalr_w(k));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_ready"}, 32'(s_ready), 32'd0);
    check({tag, "_d_w_addr"}, 32'(d_w_addr), 32'd0);
    check({tag, "_d_w_dat"}, d_w_dat, 32'd0);
    check({tag, "_d_w_enb"}, 32'(d_w_enb), 32'd0);
    check({tag, "_i_w_addr"}, 32'(i_w_addr), 32'd0);
    check({tag, "_i_w_dat"}, i_w_dat, 32'd0);
    check({tag, "_i_w_enb"}, 32'(i_w_enb), 32'd0);
    check({tag, "_init_done"}, 32'(d_bram_init_done), 32'd0);
    check({tag, "_pc_stall"}, 32'(pc_stall), 32'd1);
    check({tag, "_i_r_enb"}, 32'(i_r_enb), 32'd0);
    check({tag, "_rd_enbl"}, 32'(rd_enbl), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
  endtask

  task automatic check_running(input string tag);
    check({tag, "_pc_stall"}, 32'(pc_stall), 32'd0);
    check({tag, "_i_r_enb"}, 32'(i_r_enb), 32'd1);
    check({tag, "_rd_enbl"}, 32'(rd_enbl), 32'd1);
    check({tag, "_init_done"}, 32'(d_bram_init_done), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done_cnt"}, 32'(n_done), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Power-on reset.
    rst = 1'b0;
    repeat (3) tick();
    check_reset_outputs("por");
    rst = 1'b1;
    tick();

    // Reset held mid-stream with a word on offer.
    do_start();
    send(32'h0002_0001, 0);
    send(data_w(0), 0);
    s_valid = 1'b1;
    s_data  = 32'hdead_beef;
    rst = 1'b0;
    repeat (3) tick();
    check_reset_outputs("rst_mid");
    rst = 1'b1;
    s_valid = 1'b0;
    tick();

    // Back-to-back load: 3 data words, 6 program words.
    clear_log();
    do_start();
    send_load(32'h0006_0003, 3, 6, 0);
    repeat (3) tick();
    verify_load("load", 3, 6);
    check("load_init_rise", 32'(init_rise_edge), 32'(last_d_edge + 1));
    check("load_overlap", 32'(n_overlap), 32'd0);
    check("load_stall_fall", 32'(stall_fall_edge), 32'(last_hs_edge + 1));
    check_running("load");

    // Same load with s_valid toggling 1-0-0-1, restarted from RUN.
    clear_log();
    do_start();
    check("gap_restall", 32'(pc_stall), 32'd1);
    check("gap_rd_drop", 32'(rd_enbl), 32'd0);
    send_load(32'h0006_0003, 3, 6, 2);
    repeat (3) tick();
    verify_load("gap", 3, 6);
    check("gap_enb_pulses", 32'(n_enb), 32'd9);
    check("gap_init_rise", 32'(init_rise_edge), 32'(last_d_edge + 1));
    check("gap_overlap", 32'(n_overlap), 32'd0);
    check("gap_stall_fall", 32'(stall_fall_edge), 32'(last_hs_edge + 1));
    check_running("gap");

    // Empty header: HDR -> FLUSH -> RUN.
    clear_log();
    do_start();
    send(32'h0000_0000, 0);
    check("empty_flush_busy", 32'(busy), 32'd1);
    check("empty_flush_ready", 32'(s_ready), 32'd0);
    check("empty_flush_stall", 32'(pc_stall), 32'd1);
    check("empty_flush_done", 32'(done), 32'd0);
    tick();
    check("empty_run_done", 32'(done), 32'd1);
    check("empty_run_stall", 32'(pc_stall), 32'd0);
    tick();
    check("empty_done_once", 32'(done), 32'd0);
    check("empty_enb", 32'(n_enb), 32'd0);

    // Oversized header, then recovery.
    clear_log();
    do_start();
    send(32'h0000_0101, 0);
    check("err_flag", 32'(err), 32'd1);
    check("err_ready", 32'(s_ready), 32'd0);
    check("err_stall", 32'(pc_stall), 32'd1);
    check("err_busy", 32'(busy), 32'd0);
    s_valid = 1'b1;
    s_data  = 32'h0000_0001;
    repeat (2) tick();
    s_valid = 1'b0;
    check("err_hold", 32'(err), 32'd1);
    check("err_hold_ready", 32'(s_ready), 32'd0);
    do_start();
    check("err_clear", 32'(err), 32'd0);
    check("err_hdr_ready", 32'(s_ready), 32'd1);
    send_load(32'h0001_0002, 2, 1, 0);
    repeat (3) tick();
    verify_load("recover", 2, 1);
    check_running("recover");

    // Reset during LOAD_I after 2 program words, then reload from address 0.
    clear_log();
    do_start();
    send_load(32'h0004_0001, 1, 2, 0);
    rst = 1'b0;
    tick();
    check("rst_li_i_w_enb", 32'(i_w_enb), 32'd0);
    check("rst_li_busy", 32'(busy), 32'd0);
    check("rst_li_ready", 32'(s_ready), 32'd0);
    check("rst_li_stall", 32'(pc_stall), 32'd1);
    rst = 1'b1;
    tick();
    verify_load("pre_rst", 1, 2);
    clear_log();
    do_start();
    check("restart_ready", 32'(s_ready), 32'd1);
    send_load(32'h0002_0000, 0, 2, 0);
    repeat (3) tick();
    verify_load("restart", 0, 2);
    check("restart_done", 32'(n_done), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
